// File: rtl/pdp8_uart_pkg.sv
// Shared constants for the PDP-8 teletype UART: FSM state encoding
// (common to TX and RX), oversample ratio and counter widths.
package pdp8_uart_pkg;

   localparam int unsigned STATE_W    = 2;
   localparam int unsigned TICK_W     = 4;
   localparam int unsigned BAUD_W     = 16;
   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_SAMPLE = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Tick-count values at which a full bit period / half bit period ends
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] MID_LAST  = TICK_W'(MID_SAMPLE - 1);

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 16x-oversample baud tick generator.
// Ports: clk, reset (sync, active-high), tick (one-clk pulse every
// BAUD_DIV16 clocks, shared by transmitter and receiver).
module uart_baud_tick
   import pdp8_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV16 = 326
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   logic [BAUD_W-1:0] cnt_q;
   logic [BAUD_W-1:0] cnt_d;
   logic              tick_q;
   logic              wrap_c;

   assign wrap_c = (cnt_q == BAUD_W'(BAUD_DIV16 - 1));
   assign cnt_d  = wrap_c ? '0 : cnt_q + BAUD_W'(1);

   // Counter and registered wrap pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= wrap_c;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/pdp8_uart.sv
// Serial line interface between the PDP-8 TT controller and the RS-232
// pins: 8N1 transmitter and receiver, both timed from one shared 16x tick.
// Ports: clk, reset (sync, active-high);
//   TX: tx_data/tx_start in, tx_busy/tx_done/rs232_txd out;
//   RX: rs232_rxd/rx_ack in, rx_data/rx_ready/rx_overrun/rx_frame_err out.
module pdp8_uart
   import pdp8_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV16 = 326,
   parameter int unsigned DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_start,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 rs232_txd,
   input  logic                 rs232_rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_ready,
   input  logic                 rx_ack,
   output logic                 rx_overrun,
   output logic                 rx_frame_err
);

   localparam int unsigned      BIT_W    = $clog2(DATA_BITS + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   logic tick;

   uart_baud_tick #(
      .BAUD_DIV16 (BAUD_DIV16)
   ) u_baud_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // ---------------------------------------------------------------- TX
   logic [STATE_W-1:0]   tx_state_q, tx_state_d;
   logic [TICK_W-1:0]    tx_tick_q,  tx_tick_d;
   logic [BIT_W-1:0]     tx_bit_q,   tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_busy_q,  tx_busy_d;
   logic                 tx_done_q,  tx_done_d;
   logic                 txd_q,      txd_d;

   // TX state register
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= ST_IDLE;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_busy_q  <= 1'b0;
         tx_done_q  <= 1'b0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_tick_q  <= tx_tick_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_busy_q  <= tx_busy_d;
         tx_done_q  <= tx_done_d;
         txd_q      <= txd_d;
      end
   end

   // TX next state; a start in the tx_done cycle is refused so the
   // controller always sees one idle cycle between frames
   always_comb begin
      tx_state_d = tx_state_q;
      tx_tick_d  = tx_tick_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_busy_d  = tx_busy_q;
      tx_done_d  = 1'b0;
      txd_d      = 1'b1;

      case (tx_state_q)
         ST_IDLE: begin
            if (tx_start && !tx_busy_q && !tx_done_q) begin
               tx_shift_d = tx_data;
               tx_tick_d  = '0;
               tx_bit_d   = '0;
               tx_busy_d  = 1'b1;
               tx_state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               tx_tick_d = tx_tick_q + TICK_W'(1);
               if (tx_tick_q == TICK_LAST) begin
                  tx_state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               tx_tick_d = tx_tick_q + TICK_W'(1);
               if (tx_tick_q == TICK_LAST) begin
                  tx_shift_d = tx_shift_q >> 1;
                  tx_bit_d   = tx_bit_q + BIT_W'(1);
                  if (tx_bit_q == BIT_LAST) begin
                     tx_state_d = ST_STOP;
                  end
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               tx_tick_d = tx_tick_q + TICK_W'(1);
               if (tx_tick_q == TICK_LAST) begin
                  tx_busy_d  = 1'b0;
                  tx_done_d  = 1'b1;
                  tx_state_d = ST_IDLE;
               end
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase

      // Line level follows the state being entered so txd stays registered
      case (tx_state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = tx_shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   assign tx_busy   = tx_busy_q;
   assign tx_done   = tx_done_q;
   assign rs232_txd = txd_q;

   // ---------------------------------------------------------------- RX
   logic                 rxd_meta_q;
   logic                 rxd_s_q;
   logic [STATE_W-1:0]   rx_state_q,   rx_state_d;
   logic [TICK_W-1:0]    rx_tick_q,    rx_tick_d;
   logic [BIT_W-1:0]     rx_bit_q,     rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q,   rx_shift_d;
   logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
   logic                 rx_ready_q,   rx_ready_d;
   logic                 rx_overrun_q, rx_overrun_d;
   logic                 rx_ferr_q,    rx_ferr_d;

   // Two-flop synchroniser (idle-high) plus RX state register
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta_q   <= 1'b1;
         rxd_s_q      <= 1'b1;
         rx_state_q   <= ST_IDLE;
         rx_tick_q    <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_data_q    <= '0;
         rx_ready_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
         rx_ferr_q    <= 1'b0;
      end else begin
         rxd_meta_q   <= rs232_rxd;
         rxd_s_q      <= rxd_meta_q;
         rx_state_q   <= rx_state_d;
         rx_tick_q    <= rx_tick_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_data_q    <= rx_data_d;
         rx_ready_q   <= rx_ready_d;
         rx_overrun_q <= rx_overrun_d;
         rx_ferr_q    <= rx_ferr_d;
      end
   end

   // RX next state; a good stop bit overrides a same-cycle ack
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_tick_d    = rx_tick_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_data_d    = rx_data_q;
      rx_ready_d   = rx_ready_q;
      rx_overrun_d = rx_overrun_q;
      rx_ferr_d    = 1'b0;

      if (rx_ack && rx_ready_q) begin
         rx_ready_d   = 1'b0;
         rx_overrun_d = 1'b0;
      end

      case (rx_state_q)
         ST_IDLE: begin
            if (tick && !rxd_s_q) begin
               rx_tick_d  = '0;
               rx_bit_d   = '0;
               rx_state_d = ST_START;
            end
         end
         ST_START: begin
            // Half a bit later: still low means a real start bit
            if (tick) begin
               rx_tick_d = rx_tick_q + TICK_W'(1);
               if (rx_tick_q == MID_LAST) begin
                  rx_tick_d  = '0;
                  rx_state_d = rxd_s_q ? ST_IDLE : ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               rx_tick_d = rx_tick_q + TICK_W'(1);
               if (rx_tick_q == TICK_LAST) begin
                  rx_shift_d = {rxd_s_q, rx_shift_q[DATA_BITS-1:1]};
                  rx_bit_d   = rx_bit_q + BIT_W'(1);
                  if (rx_bit_q == BIT_LAST) begin
                     rx_state_d = ST_STOP;
                  end
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               rx_tick_d = rx_tick_q + TICK_W'(1);
               if (rx_tick_q == TICK_LAST) begin
                  rx_state_d = ST_IDLE;
                  if (rxd_s_q) begin
                     rx_data_d    = rx_shift_q;
                     rx_ready_d   = 1'b1;
                     rx_overrun_d = rx_ack ? 1'b0 : (rx_overrun_q | rx_ready_q);
                  end else begin
                     rx_ferr_d = 1'b1;
                  end
               end
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   assign rx_data      = rx_data_q;
   assign rx_ready     = rx_ready_q;
   assign rx_overrun   = rx_overrun_q;
   assign rx_frame_err = rx_ferr_q;

endmodule
